// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding and opcode/select constants for the mul/div sequencer
package muldiv_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_EXC   = 3'd4
   } state_t;
   localparam logic OP_MULT  = 1'b0;
   localparam logic OP_DIV   = 1'b1;
   localparam logic SEL_MULT = 1'b0;
   localparam logic SEL_DIV  = 1'b1;
endpackage

// File: rtl/muldiv_cycle_counter.sv
// muldiv_cycle_counter: loadable down-counter that holds at zero
module muldiv_cycle_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             en,
   output logic [CNT_W-1:0] value,
   output logic             zero
);
   assign zero = value == '0;
   always_ff @(posedge clk) begin
      if (reset) value <= '0;
      else if (load) value <= load_value;
      else if (en && !zero) value <= value - 1'b1;
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the iterative multiply/divide units and HI/LO loads, trapping divide-by-zero
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] b_operand,
   output logic        mult_init,
   output logic        mult_stop,
   output logic        div_init,
   output logic        div_stop,
   output logic        mux_high_sel,
   output logic        mux_low_sel,
   output logic        high_load,
   output logic        low_load,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc
);
   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
   state_t           state, state_n;
   logic             op_q, div_zero, accept, first, cnt_zero;
   logic [CNT_W-1:0] cnt;
   assign div_zero = op == OP_DIV && b_operand == '0;
   assign accept   = state == S_IDLE && start && !div_zero;
   muldiv_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .load_value(op == OP_DIV ? DIV_LAST : MULT_LAST),
      .en        (state == S_RUN),
      .value     (cnt),
      .zero      (cnt_zero)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         op_q  <= OP_MULT;
      end else begin
         state <= state_n;
         if (accept) op_q <= op;
      end
   end
   // the counter still holds its load value only in the first RUN cycle
   always_comb begin
      state_n      = state == S_IDLE  ? (start ? (div_zero ? S_EXC : S_RUN) : S_IDLE) :
                     state == S_RUN   ? (cnt_zero ? S_WRITE : S_RUN) :
                     state == S_WRITE ? S_DONE : S_IDLE;
      first        = state == S_RUN && cnt == (op_q == OP_DIV ? DIV_LAST : MULT_LAST);
      mult_init    = first && op_q == OP_MULT;
      div_init     = first && op_q == OP_DIV;
      high_load    = state == S_WRITE;
      low_load     = state == S_WRITE;
      mult_stop    = state == S_WRITE && op_q == OP_MULT;
      div_stop     = state == S_WRITE && op_q == OP_DIV;
      mux_high_sel = op_q == OP_DIV ? SEL_DIV : SEL_MULT;
      mux_low_sel  = op_q == OP_DIV ? SEL_DIV : SEL_MULT;
      busy         = state == S_RUN || state == S_WRITE;
      done         = state == S_DONE || state == S_EXC;
      div_zero_exc = state == S_EXC;
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: random and directed stimulus checked against a cycle-schedule reference model
module tb_muldiv_ctrl;
   localparam int MC = 32;
   localparam int DC = 32;
   logic        clk = 1'b0;
   logic        reset, start, op;
   logic [31:0] b_operand;
   logic        mult_init, mult_stop, div_init, div_stop, mux_high_sel, mux_low_sel;
   logic        high_load, low_load, busy, done, div_zero_exc;
   int          checks = 0, failures = 0, cyc_n = 0;
   bit          acc_valid = 0, acc_op = 0, acc_exc = 0, sel = 0;
   int          acc_cyc = 0, free_cyc = 0;
   muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .b_operand(b_operand),
      .mult_init(mult_init), .mult_stop(mult_stop), .div_init(div_init), .div_stop(div_stop),
      .mux_high_sel(mux_high_sel), .mux_low_sel(mux_low_sel), .high_load(high_load),
      .low_load(low_load), .busy(busy), .done(done), .div_zero_exc(div_zero_exc)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d got=%b exp=%b", tag, cyc_n, got, exp);
      end
   endtask
   function automatic logic [10:0] outs();
      return {mult_init, mult_stop, div_init, div_stop, mux_high_sel, mux_low_sel,
              high_load, low_load, busy, done, div_zero_exc};
   endfunction
   // expected outputs from the time elapsed since the last accepted request
   function automatic logic [10:0] model(int c);
      logic [10:0] e = '0;
      int k = c - acc_cyc;
      int n = acc_op ? DC : MC;
      e[6] = sel;
      e[5] = sel;
      if (acc_valid && acc_exc) begin
         if (k == 1) begin e[1] = 1'b1; e[0] = 1'b1; end
      end else if (acc_valid) begin
         if (k == 1) begin if (acc_op) e[8] = 1'b1; else e[10] = 1'b1; end
         if (k >= 1 && k <= n + 1) e[2] = 1'b1;
         if (k == n + 1) begin
            e[4] = 1'b1; e[3] = 1'b1;
            if (acc_op) e[7] = 1'b1; else e[9] = 1'b1;
         end
         if (k == n + 2) e[1] = 1'b1;
      end
      return e;
   endfunction
   task automatic cycle(input logic s, input logic o, input logic [31:0] b, input logic r);
      bit exc;
      start = s; op = o; b_operand = b; reset = r;
      @(negedge clk);
      check("outputs", outs(), model(cyc_n));
      @(posedge clk);
      if (r) begin
         acc_valid = 0; sel = 0; free_cyc = cyc_n + 1;
      end else if (s && cyc_n >= free_cyc) begin
         exc = o && b == 0;
         acc_valid = 1; acc_cyc = cyc_n; acc_op = o; acc_exc = exc;
         if (!exc) sel = o;
         free_cyc = cyc_n + (exc ? 2 : (o ? DC : MC) + 3);
      end
      cyc_n++;
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 1), $urandom, 1'b0);
   endtask
   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; b_operand = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset", outs(), 11'b0);
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 32'd5, 1'b0); idle(40);
      cycle(1'b1, 1'b1, 32'd7, 1'b0); idle(40);
      cycle(1'b1, 1'b1, 32'd0, 1'b0); idle(5);
      for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0, $urandom, 1'b0);
      idle(40);
      cycle(1'b1, 1'b0, 32'd3, 1'b0); idle(9);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b1, 1'b0, 32'd9, 1'b0); idle(40);
      cycle(1'b1, 1'b0, 32'd0, 1'b0); idle(40);
      cycle(1'b1, 1'b1, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, 32'd0, 1'b0);
      idle(3);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 1),
               $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
               $urandom_range(0, 199) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the shared iterative multiply and divide units and the HI/LO registers in the multicycle CPU datapath.
- The main control FSM issues one start pulse with an opcode and waits on busy/done.
- This block performs these steps:
  - pulses the init of the selected unit;
  - counts its fixed iteration latency;
  - asserts stop;
  - selects the unit's results into the High/Low muxes and loads both registers.
- It also detects divide-by-zero before any iteration starts and raises an exception flag instead.

Parameters:
- MULT_CYCLES, 32, iteration cycles of the multiply unit from init to valid result.
- DIV_CYCLES, 32, iteration cycles of the divide unit from init to valid result.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request from main FSM; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled together with start.
- b_operand  in  32  divisor (B register output); zero-checked at start.
- mult_init  out  1  one-cycle pulse to start the multiply unit.
- mult_stop  out  1  one-cycle pulse ending the multiply.
- div_init  out  1  one-cycle pulse to start the divide unit.
- div_stop  out  1  one-cycle pulse ending the divide.
- mux_high_sel  out  1  High mux select; 0 = mult result, 1 = div result.
- mux_low_sel  out  1  Low mux select; same encoding as mux_high_sel.
- high_load  out  1  High register load enable.
- low_load  out  1  Low register load enable.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO updated, or exception taken.
- div_zero_exc  out  1  one-cycle pulse: division by zero.

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset:
  - state = IDLE, counter = 0, op_q = 0.
  - All outputs are 0 at the next rising edge.
  - A reset during any state abandons the operation: no load, no done, no exception.
- Outputs are Moore-decoded from state and op_q. mux_high_sel = mux_low_sel = op_q, held stable from acceptance until the next accepted start.
- States and transitions (N = MULT_CYCLES or DIV_CYCLES according to op_q):
  - IDLE:
    - start=1 and op=DIV and b_operand==0 → EXC.
    - start=1 otherwise → RUN; op_q ← op; counter ← N-1.
    - start=0 → stay in IDLE.
  - RUN (busy=1):
    - The first RUN cycle asserts mult_init or div_init (per op_q) for exactly one cycle.
    - While counter != 0: counter decrements each cycle.
    - At counter == 0 → WRITE.
    - RUN lasts exactly N cycles.
  - WRITE (busy=1): assert high_load=1, low_load=1, and mult_stop or div_stop per op_q. → DONE.
  - DONE: done=1, busy=0. → IDLE.
  - EXC: div_zero_exc=1, done=1, busy=0. No init, no stop, no load. → IDLE.
- Latency for an accepted start at cycle 0:
  - init in cycle 1;
  - RUN occupies cycles 1..N;
  - WRITE in cycle N+1 (HI/LO capture on the edge ending it);
  - done in cycle N+2;
  - next start accepted in cycle N+3.
- Exception path: exc and done in cycle 1; next start accepted in cycle 2.
- start is ignored in RUN, WRITE, DONE and EXC; it is not queued.
- b_operand is examined only in the IDLE acceptance cycle; later changes are ignored.
- Multiply with b_operand == 0 is a normal operation with no exception.
- Counter never wraps: it is loaded only in IDLE and stops at 0.

Decomposition:
- Package muldiv_pkg holds:
  - the state encoding (IDLE, RUN, WRITE, DONE, EXC; 3 bits);
  - OP_MULT = 1'b0 and OP_DIV = 1'b1;
  - the mux select constants SEL_MULT = 0 and SEL_DIV = 1.
- One sub-module, muldiv_cycle_counter: loadable down-counter with synchronous reset, load, value and zero outputs, width CNT_W.
- The FSM and output decode stay in muldiv_ctrl.

Test Plan:
- Reset then start=1, op=0, b=5 in cycle 0 → all of:
  - mult_init=1 only in cycle 1;
  - busy=1 in cycles 1..33;
  - high_load=low_load=mult_stop=1 only in cycle 33, with sel=0;
  - done=1 only in cycle 34;
  - div_* and div_zero_exc stay 0.
- start=1, op=1, b=7 in cycle 0 → all of:
  - div_init in cycle 1;
  - mux_high_sel=mux_low_sel=1 from cycle 1;
  - loads and div_stop in cycle 33;
  - done in cycle 34.
- start=1, op=1, b=0 in cycle 0 → div_zero_exc=1 and done=1 in cycle 1 only; no init, stop or load at any time; busy stays 0.
- start held at 1 continuously with op=0:
  - first operation done in cycle 34;
  - second init in cycle 36;
  - no extra init pulses in cycles 2..35.
- Multiply accepted in cycle 0, reset=1 in cycle 10:
  - from cycle 11, all outputs 0 and no load or done;
  - start in cycle 11 is accepted, with init in cycle 12.
- start=1, op=0, b=0 → normal 32-cycle multiply with done in cycle 34 and no exception.
